clk_div_bank: RTL and testbench

CLK_DIV_BANK -- requirements
Module: clk_div_bank

---
 rtl/clk_div_pkg.sv | 29 ++
 rtl/clk_div_chan.sv | 82 ++++++++
 rtl/clk_div_bank.sv | 73 +++++++
 tb/tb_clk_div_bank.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared constants and per-channel state record for the clock divider bank.
package clk_div_pkg;

    localparam int unsigned CW_DEF      = 16;
    localparam int unsigned DIV_RST_DEF = 16;
    localparam int unsigned ST_W        = 32;

    // Fields sized for the widest supported counter; narrower builds zero-extend.
    typedef struct packed {
        logic [ST_W-1:0] cnt;
        logic [ST_W-1:0] div_a;
        logic [ST_W-1:0] high_a;
        logic [ST_W-1:0] div_s;
        logic [ST_W-1:0] high_s;
        logic            pend;
    } chan_st_t;

    function automatic chan_st_t chan_reset(input int unsigned div_rst);
        chan_st_t st;
        st.cnt    = '0;
        st.div_a  = ST_W'(div_rst);
        st.high_a = ST_W'(div_rst / 2);
        st.div_s  = ST_W'(div_rst);
        st.high_s = ST_W'(div_rst / 2);
        st.pend   = 1'b0;
        return st;
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: period counter, shadowed period/high-time, glitch-free apply.
// Optional period-start strobe when CLK_DIV_TICK_EN is defined.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int unsigned CW      = CW_DEF,
    parameter int unsigned DIV_RST = DIV_RST_DEF
) (
    input  logic          clkin,
    input  logic          rst,
    input  logic          en,
    input  logic          wr,
    input  logic [CW-1:0] wr_div,
    input  logic [CW-1:0] wr_high,
    output logic          pend,
`ifdef CLK_DIV_TICK_EN
    output logic          tick,
`endif
    output logic          clkout
);

    chan_st_t st;
    logic     run;
    logic     wrap_c;

    assign pend   = st.pend;
    assign wrap_c = (st.cnt == st.div_a - ST_W'(1));

    always_ff @(posedge clkin) begin
        if (rst) begin
            st     <= chan_reset(DIV_RST);
            run    <= 1'b0;
            clkout <= 1'b0;
        end else begin
            if (!en) begin
                st.cnt <= '0;
                run    <= 1'b0;
                clkout <= 1'b0;
                if (st.pend) begin
                    st.div_a  <= st.div_s;
                    st.high_a <= st.high_s;
                    st.pend   <= 1'b0;
                end
            end else if (!run) begin
                run    <= 1'b1;
                st.cnt <= '0;
                clkout <= (st.high_a != '0);
            end else if (wrap_c) begin
                // New period takes effect on the wrap edge itself
                st.cnt <= '0;
                if (st.pend) begin
                    st.div_a  <= st.div_s;
                    st.high_a <= st.high_s;
                    st.pend   <= 1'b0;
                    clkout    <= (st.high_s != '0);
                end else begin
                    clkout <= (st.high_a != '0);
                end
            end else begin
                st.cnt <= st.cnt + ST_W'(1);
                clkout <= ((st.cnt + ST_W'(1)) < st.high_a);
            end

            if (wr) begin
                st.div_s  <= ST_W'(wr_div);
                st.high_s <= ST_W'(wr_high);
                st.pend   <= 1'b1;
            end
        end
    end

`ifdef CLK_DIV_TICK_EN
    always_ff @(posedge clkin) begin
        if (rst) begin
            tick <= 1'b0;
        end else begin
            tick <= en && (!run || wrap_c);
        end
    end
`endif

endmodule

// File: rtl/clk_div_bank.sv
// Bank of CH clock dividers with a shared valid/ready reconfiguration port.
// Define CLK_DIV_TICK_EN to add the per-channel period-start tick output.
module clk_div_bank
    import clk_div_pkg::*;
#(
    parameter  int unsigned CH      = 2,
    parameter  int unsigned CW      = CW_DEF,
    parameter  int unsigned DIV_RST = DIV_RST_DEF,
    localparam int unsigned CHW     = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic           clkin,
    input  logic           rst,
    input  logic [CH-1:0]  ch_en,
    input  logic           cfg_valid,
    output logic           cfg_ready,
    input  logic [CHW-1:0] cfg_ch,
    input  logic [CW-1:0]  cfg_div,
    input  logic [CW-1:0]  cfg_high,
    output logic           cfg_err,
`ifdef CLK_DIV_TICK_EN
    output logic [CH-1:0]  tick,
`endif
    output logic [CH-1:0]  clkout
);

    logic [CH-1:0] pend;
    logic [CH-1:0] wr_c;
    logic          sel_pend_c;
    logic          bad_c;
    logic          acc_c;

    // Out-of-range channels never block; they are accepted and rejected
    always_comb begin
        sel_pend_c = 1'b0;
        for (int unsigned i = 0; i < CH; i++) begin
            if (cfg_ch == CHW'(i)) sel_pend_c = pend[i];
        end
    end

    assign cfg_ready = !rst && !sel_pend_c;
    assign acc_c     = cfg_valid && cfg_ready;
    assign bad_c     = (cfg_div < CW'(2)) || (32'(cfg_ch) >= CH);

    always_ff @(posedge clkin) begin
        if (rst) begin
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= acc_c && bad_c;
        end
    end

    for (genvar g = 0; g < CH; g++) begin : g_chan
        assign wr_c[g] = acc_c && !bad_c && (cfg_ch == CHW'(g));

        clk_div_chan #(
            .CW      (CW),
            .DIV_RST (DIV_RST)
        ) u_chan (
            .clkin   (clkin),
            .rst     (rst),
            .en      (ch_en[g]),
            .wr      (wr_c[g]),
            .wr_div  (cfg_div),
            .wr_high (cfg_high),
            .pend    (pend[g]),
`ifdef CLK_DIV_TICK_EN
            .tick    (tick[g]),
`endif
            .clkout  (clkout[g])
        );
    end

endmodule

// File: tb/tb_clk_div_bank.sv
// Randomized bench for clk_div_bank against a period/phase reference model.
module tb_clk_div_bank;

    localparam int unsigned CH      = 3;
    localparam int unsigned CW      = 8;
    localparam int unsigned DIV_RST = 16;
    localparam int unsigned CHW     = 2;

    logic           clkin = 1'b0;
    logic           rst;
    logic [CH-1:0]  ch_en;
    logic           cfg_valid;
    logic           cfg_ready;
    logic [CHW-1:0] cfg_ch;
    logic [CW-1:0]  cfg_div;
    logic [CW-1:0]  cfg_high;
    logic           cfg_err;
    logic [CH-1:0]  clkout;
`ifdef CLK_DIV_TICK_EN
    logic [CH-1:0]  tick;
`endif

    always #5 clkin = ~clkin;

    clk_div_bank #(
        .CH      (CH),
        .CW      (CW),
        .DIV_RST (DIV_RST)
    ) dut (
        .clkin     (clkin),
        .rst       (rst),
        .ch_en     (ch_en),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_high  (cfg_high),
        .cfg_err   (cfg_err),
`ifdef CLK_DIV_TICK_EN
        .tick      (tick),
`endif
        .clkout    (clkout)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: period length, high time and phase within the period
    longint       m_div_a [CH];
    longint       m_high_a[CH];
    longint       m_div_s [CH];
    longint       m_high_s[CH];
    bit           m_pend  [CH];
    bit           m_run   [CH];
    longint       m_pos   [CH];
    logic [CH-1:0] e_clk;
    logic [CH-1:0] e_tick;
    logic          e_err;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit exp_ready();
        if (rst) return 1'b0;
        if (32'(cfg_ch) >= CH) return 1'b1;
        return !m_pend[cfg_ch];
    endfunction

    task automatic model_edge();
        bit acc;
        bit badreq;
        if (rst) begin
            for (int i = 0; i < CH; i++) begin
                m_div_a[i] = DIV_RST;  m_high_a[i] = DIV_RST / 2;
                m_div_s[i] = DIV_RST;  m_high_s[i] = DIV_RST / 2;
                m_pend[i] = 0; m_run[i] = 0; m_pos[i] = 0;
            end
            e_clk = '0; e_tick = '0; e_err = 1'b0;
        end else begin
            acc    = cfg_valid && exp_ready();
            badreq = (cfg_div < 2) || (32'(cfg_ch) >= CH);
            e_err  = acc && badreq;
            for (int i = 0; i < CH; i++) begin
                e_tick[i] = 1'b0;
                if (!ch_en[i]) begin
                    m_run[i] = 0; m_pos[i] = 0; e_clk[i] = 1'b0;
                    if (m_pend[i]) begin
                        m_div_a[i] = m_div_s[i]; m_high_a[i] = m_high_s[i]; m_pend[i] = 0;
                    end
                end else if (!m_run[i]) begin
                    m_run[i] = 1; m_pos[i] = 0;
                    e_clk[i] = (m_high_a[i] > 0); e_tick[i] = 1'b1;
                end else begin
                    m_pos[i] = (m_pos[i] + 1) % m_div_a[i];
                    if (m_pos[i] == 0) begin
                        e_tick[i] = 1'b1;
                        if (m_pend[i]) begin
                            m_div_a[i] = m_div_s[i]; m_high_a[i] = m_high_s[i]; m_pend[i] = 0;
                        end
                    end
                    e_clk[i] = (m_pos[i] < m_high_a[i]);
                end
            end
            if (acc && !badreq) begin
                m_div_s[cfg_ch]  = cfg_div;
                m_high_s[cfg_ch] = cfg_high;
                m_pend[cfg_ch]   = 1;
            end
        end
    endtask

    // One clock: check ready before the edge, advance model, check outputs after
    task automatic cyc();
        #1;
        chk("cfg_ready", 64'(cfg_ready), 64'(exp_ready()));
        @(posedge clkin);
        model_edge();
        #1;
        chk("clkout", 64'(clkout), 64'(e_clk));
        chk("cfg_err", 64'(cfg_err), 64'(e_err));
`ifdef CLK_DIV_TICK_EN
        chk("tick", 64'(tick), 64'(e_tick));
`endif
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cyc();
    endtask

    task automatic req(input int ch, input int dv, input int hi);
        cfg_valid = 1'b1;
        cfg_ch    = CHW'(ch);
        cfg_div   = CW'(dv);
        cfg_high  = CW'(hi);
        cyc();
        cfg_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; ch_en = '0; cfg_valid = 1'b0;
        cfg_ch = '0; cfg_div = '0; cfg_high = '0;
        run(3);
        rst = 1'b0;
        cyc();

        // Default 16-cycle period on ch0 only
        ch_en = 3'b001;
        run(40);

        // Reprogram ch0 mid-period to 5/2
        for (int n = 0; n < 40 && m_pos[0] != 2; n++) cyc();
        req(0, 5, 2);
        run(30);

        // Rejected requests: too-short period and out-of-range channel
        req(0, 1, 0);
        run(3);
        req(3, 5, 1);
        run(3);

        // Constant low, then constant high
        req(0, 6, 0);
        run(20);
        req(0, 6, 9);
        run(20);

        // Disable ch1 with an update pending, then re-enable
        ch_en = 3'b011;
        run(10);
        req(1, 7, 3);
        ch_en = 3'b001;
        run(4);
        ch_en = 3'b011;
        run(20);

        // Reset with an update pending
        ch_en = 3'b111;
        req(2, 9, 4);
        rst = 1'b1;
        run(2);
        rst = 1'b0;
        run(40);

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            rst = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 19) == 0) ch_en = CH'($urandom);
            cfg_valid = ($urandom_range(0, 3) == 0);
            cfg_ch    = CHW'($urandom_range(0, 3));
            cfg_div   = CW'($urandom_range(0, 12));
            cfg_high  = CW'($urandom_range(0, 14));
            cyc();
        end
        rst = 1'b0; cfg_valid = 1'b0;
        run(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
